wb_arbiter_2: RTL and testbench
===============================

Name: wb_arbiter_2

Overview:
- Two-master, one-slave Wishbone arbiter with a bus-timeout watchdog.
- Sits in front of the peripheral interconnect inside the digital core.
- Shares the peripheral bus between the Caravel Wishbone master (master 0) and a second on-chip master (master 1, e.g. a logic-analyzer-driven bridge or sweep sequencer).
- The watchdog guarantees a hung or unmapped slave never locks the bus.

Parameters:
- TIMEOUT_CYCLES, 255: cycles a strobed access may wait for ack before abort; 0 disables the watchdog.
- TIMEOUT_BITS, 8: width of the watchdog counter; must satisfy TIMEOUT_CYCLES < 2**TIMEOUT_BITS.
- PRIO_M0_FIRST, 1: winner of the first contention after reset (1 = master 0, 0 = master 1).

Ports:
- wb_clk_i  in  1  bus clock
- wb_rst_i  in  1  synchronous, active-high reset
- wbm0_cyc_i, wbm0_stb_i, wbm0_we_i  in  1 each  master 0 control
- wbm0_sel_i  in  4  master 0 byte select
- wbm0_adr_i, wbm0_dat_i  in  32 each  master 0 address / write data
- wbm0_dat_o  out  32  master 0 read data
- wbm0_ack_o, wbm0_err_o  out  1 each  master 0 ack / timeout error
- wbm1_*  same set as wbm0_*  master 1
- wbs_cyc_o, wbs_stb_o, wbs_we_o  out  1 each  slave control
- wbs_sel_o  out  4  slave byte select
- wbs_adr_o, wbs_dat_o  out  32 each  slave address / write data
- wbs_dat_i  in  32  slave read data
- wbs_ack_i  in  1  slave ack
- grant_o  out  2  one-hot current owner ({m1,m0}); 00 = idle
- timeout_o  out  1  one-cycle pulse on a watchdog abort

Behaviour:
- Reset values: grant = 00, last-owner pointer = PRIO_M0_FIRST ? m1 : m0, watchdog = 0, all outputs 0.
- FSM states: IDLE, OWN0, OWN1. Grant is a registered, one-hot decode of the state.
- IDLE:
  - Exactly one wbmN_cyc_i high -> OWNN next cycle.
  - Both high -> the master that did not own last wins (round robin).
  - Neither high -> stay in IDLE.
- OWNn:
  - Hold while wbmn_cyc_i = 1; stb may toggle, so multiple accesses and blocks are allowed without re-arbitration.
  - wbmn_cyc_i = 0 -> IDLE next cycle and last-owner <= n.
  - Every handover therefore passes through at least one IDLE cycle.
- Grant latency: request cycle T -> grant register at T+1 -> slave sees cyc/stb combinationally during T+1.
- Slave-side outputs are combinational muxes of the owning master's inputs. In IDLE every wbs_* output is 0.
- Master-side returns:
  - Owner: wbmN_dat_o = wbs_dat_i; wbmN_ack_o = wbs_ack_i & wbmN_stb_i & ~abort.
  - Non-owner: dat, ack and err held at 0.
- A non-owner's stb is ignored and its master stalls; no ack is ever given to a non-owner.
- Watchdog:
  - Counter clears on IDLE, on ack, and on any cycle with owner stb = 0.
  - Increments each cycle the owner has cyc & stb high and wbs_ack_i = 0.
  - Abort condition: counter == TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0).
- On abort (one cycle):
  - wbmN_err_o = 1, timeout_o = 1.
  - wbs_cyc_o and wbs_stb_o forced to 0.
  - A wbs_ack_i arriving in the same cycle is dropped.
  - Counter clears. Ownership is kept until the master drops cyc.
- ack and err are never both asserted in the same cycle.
- Reset mid-access: grant drops to 00 the next edge and wbs_cyc_o drops with it. No ack or err is emitted for the killed access.
- Owner dropping cyc while stb is pending: the access is abandoned, and a late slave ack in the IDLE cycle is ignored.

Decomposition:
- Shared package wb_arb_pkg holds:
  - state encoding constants ARB_IDLE = 2'd0, ARB_OWN0 = 2'd1, ARB_OWN1 = 2'd2;
  - grant one-hot constants;
  - WB_ADR_W = 32, WB_DAT_W = 32, WB_SEL_W = 4.
- One sub-module, wb_timeout_ctr: parameterised counter with clear/inc inputs and an expire output. It is reusable by future bridges.
- The arbiter FSM and muxes stay in wb_arbiter_2.

Test Plan:
- Single master: after reset, m0 write adr 0x3000_0004 dat 0xDEAD_BEEF, slave acks 2 cycles after stb -> grant_o = 01 one cycle after cyc; wbs_* mirrors m0; wbm0_ack_o one cycle; grant returns to 00 the cycle after cyc drops.
- Contention round robin: m0 and m1 raise cyc in the same cycle, 3 times back-to-back.
  - Expect grant order m0, m1, m0 (PRIO_M0_FIRST = 1).
  - Each handover has one IDLE cycle.
  - The non-owner sees ack = 0 throughout.
- Block transfer: m1 holds cyc for 4 stb/ack pairs while m0 requests -> m1 keeps the grant for all 4; m0 is granted only after m1 drops cyc.
- Timeout: TIMEOUT_CYCLES = 8, slave never acks m0 read -> wbm0_err_o and timeout_o pulse exactly 8 cycles after stb; wbs_stb_o = 0 in that cycle; no ack; grant held until m0 drops cyc.
- Ack and timeout collide: slave ack lands on the abort cycle -> err = 1, ack = 0. Also, TIMEOUT_CYCLES = 0 with a 300-cycle stall -> no err, and ack is passed when it finally arrives.
- Reset mid-access: assert wb_rst_i while m1 owns with stb pending -> next edge grant_o = 00, all wbs_* = 0, no ack/err; the first post-reset contention goes to m0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
// Shared definitions for the two-master Wishbone arbiter: bus widths, the
// arbiter state encoding, the one-hot grant codes and the state->grant decode.
// -----------------------------------------------------------------------------
package wb_arb_pkg;

  localparam int unsigned WB_ADR_W = 32;
  localparam int unsigned WB_DAT_W = 32;
  localparam int unsigned WB_SEL_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  // Grant is one-hot {m1, m0}; all-zero means nobody owns the bus.
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  function automatic logic [1:0] grant_of(arb_state_e s);
    case (s)
      ARB_OWN0: return GRANT_M0;
      ARB_OWN1: return GRANT_M1;
      default:  return GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/wb_arbiter_2_if.sv
// -----------------------------------------------------------------------------
// wb_arbiter_2_if
// One Wishbone classic link. The master modport drives the request side
// (cyc/stb/we/sel/adr/dat_w) and receives dat_r/ack/err; the slave modport is
// the mirror image.
// -----------------------------------------------------------------------------
interface wb_arbiter_2_if;
  import wb_arb_pkg::*;

  logic                cyc;
  logic                stb;
  logic                we;
  logic [WB_SEL_W-1:0] sel;
  logic [WB_ADR_W-1:0] adr;
  logic [WB_DAT_W-1:0] dat_w;
  logic [WB_DAT_W-1:0] dat_r;
  logic                ack;
  logic                err;

  modport master (
    output cyc, stb, we, sel, adr, dat_w,
    input  dat_r, ack, err
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_w,
    output dat_r, ack, err
  );

endinterface

// File: rtl/wb_timeout_ctr.sv
// -----------------------------------------------------------------------------
// wb_timeout_ctr
// Bus watchdog counter. Counts cycles while inc is high, returns to zero on
// clr (clr wins over inc), and raises expire while the count equals LIMIT.
// LIMIT = 0 disables expiry entirely. LIMIT must be below 2**BITS.
//
// Ports:
//   clk    in  clock
//   rst    in  synchronous active-high reset
//   clr    in  clear the count this cycle
//   inc    in  advance the count this cycle
//   expire out count has reached LIMIT
// -----------------------------------------------------------------------------
module wb_timeout_ctr #(
  parameter int unsigned LIMIT = 255,
  parameter int unsigned BITS  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam logic [BITS-1:0] LIMIT_V = BITS'(LIMIT);

  logic [BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: cnt_d gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignment so every flop samples the
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (LIMIT != 0) && (cnt_q == LIMIT_V);

endmodule

// File: rtl/wb_arbiter_2.sv
// -----------------------------------------------------------------------------
// wb_arbiter_2
// Two-master, one-slave Wishbone arbiter with a bus-timeout watchdog.
// Ownership is held for the whole cyc of the winning master; contention out
// of IDLE is resolved round robin against the previous owner. A stalled
// strobe that waits TIMEOUT_CYCLES cycles is aborted with a one-cycle err
// to the owner so an unmapped slave can never lock the bus.
//
// Ports:
//   wb_clk_i   in   bus clock
//   wb_rst_i   in   synchronous active-high reset
//   wbm0       slave modport  master 0 (Caravel) link
//   wbm1       slave modport  master 1 (on-chip) link
//   wbs        master modport shared peripheral slave link (err unused)
//   grant_o    out  registered one-hot owner {m1,m0}, 00 = idle
//   timeout_o  out  one-cycle pulse on a watchdog abort
// -----------------------------------------------------------------------------
module wb_arbiter_2
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_BITS   = 8,
  parameter bit          PRIO_M0_FIRST  = 1'b1
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  wb_arbiter_2_if.slave  wbm0,
  wb_arbiter_2_if.slave  wbm1,
  wb_arbiter_2_if.master wbs,
  output logic [1:0]     grant_o,
  output logic           timeout_o
);

  // Pointer reset value: claiming m1 owned last makes m0 win the first tie.
  localparam logic LAST_M1_RST = PRIO_M0_FIRST;

  arb_state_e state_q, state_d;
  logic       last_m1_q, last_m1_d;
  logic [1:0] grant_q, grant_d;

  logic own0, own1;
  logic owner_cyc, owner_stb;
  logic wd_clr, wd_inc, wd_expire, abort;

  // --------------------------------------------------------------------------
  // Ownership FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    last_m1_d = last_m1_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (wbm0.cyc && wbm1.cyc) begin
          state_d = last_m1_q ? ARB_OWN0 : ARB_OWN1;
        end else if (wbm0.cyc) begin
          state_d = ARB_OWN0;
        end else if (wbm1.cyc) begin
          state_d = ARB_OWN1;
        end
      end
      ARB_OWN0: begin
        if (!wbm0.cyc) begin
          state_d   = ARB_IDLE;
          last_m1_d = 1'b0;
        end
      end
      ARB_OWN1: begin
        if (!wbm1.cyc) begin
          state_d   = ARB_IDLE;
          last_m1_d = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    // Grant is registered from the next state so it always matches state_q.
    grant_d = grant_of(state_d);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ARB_IDLE;
      last_m1_q <= LAST_M1_RST;
      grant_q   <= GRANT_NONE;
    end else begin
      state_q   <= state_d;
      last_m1_q <= last_m1_d;
      grant_q   <= grant_d;
    end
  end

  assign own0 = (state_q == ARB_OWN0);
  assign own1 = (state_q == ARB_OWN1);

  assign owner_cyc = (own0 & wbm0.cyc) | (own1 & wbm1.cyc);
  assign owner_stb = (own0 & wbm0.stb) | (own1 & wbm1.stb);

  // --------------------------------------------------------------------------
  // Watchdog: counts cycles an owner strobe waits for ack. The abort cycle
  // itself clears the count so a master that keeps strobing gets a fresh
  // window rather than a continuous err.
  // --------------------------------------------------------------------------
  assign wd_inc = owner_cyc & owner_stb & ~wbs.ack;
  assign wd_clr = ~(owner_cyc & owner_stb) | wbs.ack | abort;

  wb_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES),
    .BITS  (TIMEOUT_BITS)
  ) u_timeout_ctr (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .clr    (wd_clr),
    .inc    (wd_inc),
    .expire (wd_expire)
  );

  assign abort = wd_expire & (own0 | own1);

  // --------------------------------------------------------------------------
  // Slave-side mux: owner's request, all zero when idle; cyc/stb are pulled
  // low in the abort cycle so the slave sees the access end.
  // --------------------------------------------------------------------------
  always_comb begin
    wbs.we    = 1'b0;
    wbs.sel   = '0;
    wbs.adr   = '0;
    wbs.dat_w = '0;
    if (own0) begin
      wbs.we    = wbm0.we;
      wbs.sel   = wbm0.sel;
      wbs.adr   = wbm0.adr;
      wbs.dat_w = wbm0.dat_w;
    end else if (own1) begin
      wbs.we    = wbm1.we;
      wbs.sel   = wbm1.sel;
      wbs.adr   = wbm1.adr;
      wbs.dat_w = wbm1.dat_w;
    end
  end

  assign wbs.cyc = owner_cyc & ~abort;
  assign wbs.stb = owner_stb & ~abort;

  // --------------------------------------------------------------------------
  // Master-side returns: only the owner ever sees data, ack or err. An ack
  // that lands on the abort cycle is dropped so ack and err never coincide.
  // --------------------------------------------------------------------------
  assign wbm0.dat_r = own0 ? wbs.dat_r : '0;
  assign wbm0.ack   = own0 & wbs.ack & wbm0.stb & ~abort;
  assign wbm0.err   = own0 & abort;

  assign wbm1.dat_r = own1 ? wbs.dat_r : '0;
  assign wbm1.ack   = own1 & wbs.ack & wbm1.stb & ~abort;
  assign wbm1.err   = own1 & abort;

  assign grant_o   = grant_q;
  assign timeout_o = abort;

  // The shared slave has no error return of its own.
  logic unused_wbs_err;
  assign unused_wbs_err = wbs.err;

endmodule

// File: tb/tb_wb_arbiter_2.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter_2
// Directed bench for wb_arbiter_2. The main instance uses an 8-cycle
// watchdog; a second instance with the watchdog disabled shares the same
// master/slave stimulus for the long-stall case.
// -----------------------------------------------------------------------------
module tb_wb_arbiter_2;

  logic       clk;
  logic       rst;
  logic [1:0] grant, grant_nt;
  logic       timeout, timeout_nt;

  int checks;
  int failures;

  wb_arbiter_2_if m0_if ();
  wb_arbiter_2_if m1_if ();
  wb_arbiter_2_if s_if ();
  wb_arbiter_2_if m0n_if ();
  wb_arbiter_2_if m1n_if ();
  wb_arbiter_2_if sn_if ();

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter_2 #(
    .TIMEOUT_CYCLES (8),
    .TIMEOUT_BITS   (8),
    .PRIO_M0_FIRST  (1'b1)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbm0      (m0_if),
    .wbm1      (m1_if),
    .wbs       (s_if),
    .grant_o   (grant),
    .timeout_o (timeout)
  );

  wb_arbiter_2 #(
    .TIMEOUT_CYCLES (0),
    .TIMEOUT_BITS   (8),
    .PRIO_M0_FIRST  (1'b1)
  ) dut_nt (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbm0      (m0n_if),
    .wbm1      (m1n_if),
    .wbs       (sn_if),
    .grant_o   (grant_nt),
    .timeout_o (timeout_nt)
  );

  assign s_if.err  = 1'b0;
  assign sn_if.err = 1'b0;

  // Mirror the stimulus onto the no-watchdog instance.
  assign m0n_if.cyc   = m0_if.cyc;
  assign m0n_if.stb   = m0_if.stb;
  assign m0n_if.we    = m0_if.we;
  assign m0n_if.sel   = m0_if.sel;
  assign m0n_if.adr   = m0_if.adr;
  assign m0n_if.dat_w = m0_if.dat_w;
  assign m1n_if.cyc   = m1_if.cyc;
  assign m1n_if.stb   = m1_if.stb;
  assign m1n_if.we    = m1_if.we;
  assign m1n_if.sel   = m1_if.sel;
  assign m1n_if.adr   = m1_if.adr;
  assign m1n_if.dat_w = m1_if.dat_w;
  assign sn_if.ack    = s_if.ack;
  assign sn_if.dat_r  = s_if.dat_r;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic cyc, input logic stb, input logic we,
                        input logic [31:0] adr, input logic [31:0] dat);
    m0_if.cyc   = cyc;
    m0_if.stb   = stb;
    m0_if.we    = we;
    m0_if.sel   = 4'hF;
    m0_if.adr   = adr;
    m0_if.dat_w = dat;
  endtask

  task automatic set_m1(input logic cyc, input logic stb, input logic we,
                        input logic [31:0] adr, input logic [31:0] dat);
    m1_if.cyc   = cyc;
    m1_if.stb   = stb;
    m1_if.we    = we;
    m1_if.sel   = 4'hF;
    m1_if.adr   = adr;
    m1_if.dat_w = dat;
  endtask

  task automatic idle_all();
    set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    s_if.ack   = 1'b0;
    s_if.dat_r = 32'h0;
  endtask

  initial begin
    logic       early;
    logic [1:0] exp_grant;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle_all();
    tick();
    tick();

    // ---------------- reset state
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_wbs_cyc", 32'(s_if.cyc), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    check("rst_m0_ack", 32'(m0_if.ack), 32'h0);
    check("rst_m1_err", 32'(m1_if.err), 32'h0);
    rst = 1'b0;

    // ---------------- single master write
    set_m0(1'b1, 1'b1, 1'b1, 32'h3000_0004, 32'hDEAD_BEEF);
    #1;
    check("t1_req_grant", 32'(grant), 32'h0);
    check("t1_req_wbs_cyc", 32'(s_if.cyc), 32'h0);
    tick();
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_wbs_cyc", 32'(s_if.cyc), 32'h1);
    check("t1_wbs_stb", 32'(s_if.stb), 32'h1);
    check("t1_wbs_we", 32'(s_if.we), 32'h1);
    check("t1_wbs_adr", s_if.adr, 32'h3000_0004);
    check("t1_wbs_dat", s_if.dat_w, 32'hDEAD_BEEF);
    check("t1_wbs_sel", 32'(s_if.sel), 32'hF);
    check("t1_wait_ack0", 32'(m0_if.ack), 32'h0);
    tick();
    check("t1_wait_ack1", 32'(m0_if.ack), 32'h0);
    tick();
    s_if.ack   = 1'b1;
    s_if.dat_r = 32'h1234_5678;
    #1;
    check("t1_m0_ack", 32'(m0_if.ack), 32'h1);
    check("t1_m0_dat", m0_if.dat_r, 32'h1234_5678);
    check("t1_m0_err", 32'(m0_if.err), 32'h0);
    check("t1_m1_ack", 32'(m1_if.ack), 32'h0);
    check("t1_m1_dat", m1_if.dat_r, 32'h0);
    tick();
    s_if.ack   = 1'b0;
    s_if.dat_r = 32'h0;
    set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("t1_ack_one_cycle", 32'(m0_if.ack), 32'h0);
    check("t1_grant_hold", 32'(grant), 32'h1);
    check("t1_drop_wbs_cyc", 32'(s_if.cyc), 32'h0);
    tick();
    check("t1_grant_release", 32'(grant), 32'h0);

    // Restore the priority pointer before the contention sequence.
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // ---------------- round robin: m0, m1, m0
    for (int r = 0; r < 3; r++) begin
      exp_grant = (r == 1) ? 2'b10 : 2'b01;
      set_m0(1'b1, 1'b1, 1'b0, 32'h3000_0020, 32'h0);
      set_m1(1'b1, 1'b1, 1'b0, 32'h3000_0040, 32'h0);
      #1;
      check("t2_idle_gap", 32'(grant), 32'h0);
      tick();
      check("t2_grant", 32'(grant), 32'(exp_grant));
      s_if.ack = 1'b1;
      #1;
      check("t2_win_ack", 32'(exp_grant[0] ? m0_if.ack : m1_if.ack), 32'h1);
      check("t2_lose_ack", 32'(exp_grant[0] ? m1_if.ack : m0_if.ack), 32'h0);
      tick();
      s_if.ack = 1'b0;
      if (exp_grant[0]) set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      else              set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      check("t2_grant_hold", 32'(grant), 32'(exp_grant));
      check("t2_lose_ack_hold", 32'(exp_grant[0] ? m1_if.ack : m0_if.ack), 32'h0);
      tick();
    end
    idle_all();
    #1;
    check("t2_final_idle", 32'(grant), 32'h0);
    tick();
    check("t2_stay_idle", 32'(grant), 32'h0);

    // ---------------- block transfer by m1 while m0 waits
    set_m1(1'b1, 1'b1, 1'b0, 32'h3000_0100, 32'h0);
    tick();
    set_m0(1'b1, 1'b1, 1'b0, 32'h3000_0200, 32'h0);
    for (int k = 0; k < 4; k++) begin
      m1_if.adr = 32'h3000_0100 + 32'(4 * k);
      m1_if.stb = 1'b1;
      s_if.ack  = 1'b1;
      #1;
      check("t3_grant", 32'(grant), 32'h2);
      check("t3_adr", s_if.adr, 32'h3000_0100 + 32'(4 * k));
      check("t3_m1_ack", 32'(m1_if.ack), 32'h1);
      check("t3_m0_ack", 32'(m0_if.ack), 32'h0);
      tick();
      m1_if.stb = 1'b0;
      s_if.ack  = 1'b0;
      #1;
      check("t3_grant_gap", 32'(grant), 32'h2);
      tick();
    end
    set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("t3_drop_hold", 32'(grant), 32'h2);
    tick();
    check("t3_idle", 32'(grant), 32'h0);
    check("t3_idle_m0_ack", 32'(m0_if.ack), 32'h0);
    tick();
    check("t3_m0_granted", 32'(grant), 32'h1);
    idle_all();
    tick();
    check("t3_release", 32'(grant), 32'h0);

    // ---------------- timeout: slave never acks an m0 read
    set_m0(1'b1, 1'b1, 1'b0, 32'h3000_0008, 32'h0);
    tick();
    early = 1'b0;
    for (int i = 0; i < 8; i++) begin
      early = early | m0_if.err | timeout | m0_if.ack;
      tick();
    end
    check("t4_no_early_err", 32'(early), 32'h0);
    check("t4_err", 32'(m0_if.err), 32'h1);
    check("t4_timeout", 32'(timeout), 32'h1);
    check("t4_wbs_stb", 32'(s_if.stb), 32'h0);
    check("t4_wbs_cyc", 32'(s_if.cyc), 32'h0);
    check("t4_ack", 32'(m0_if.ack), 32'h0);
    check("t4_grant", 32'(grant), 32'h1);
    tick();
    check("t4_err_pulse", 32'(m0_if.err), 32'h0);
    check("t4_timeout_pulse", 32'(timeout), 32'h0);
    check("t4_grant_kept", 32'(grant), 32'h1);
    check("t4_stb_back", 32'(s_if.stb), 32'h1);
    set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("t4_release", 32'(grant), 32'h0);

    // ---------------- ack collides with abort
    set_m0(1'b1, 1'b1, 1'b0, 32'h3000_000C, 32'h0);
    tick();
    for (int i = 0; i < 8; i++) tick();
    s_if.ack = 1'b1;
    #1;
    check("t5_err", 32'(m0_if.err), 32'h1);
    check("t5_ack_dropped", 32'(m0_if.ack), 32'h0);
    check("t5_timeout", 32'(timeout), 32'h1);
    tick();
    s_if.ack = 1'b0;
    set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("t5_release", 32'(grant), 32'h0);

    // ---------------- watchdog disabled: 300-cycle stall
    set_m0(1'b1, 1'b1, 1'b0, 32'h3000_0010, 32'h0);
    tick();
    early = 1'b0;
    for (int i = 0; i < 300; i++) begin
      early = early | m0n_if.err | timeout_nt | m0n_if.ack;
      tick();
    end
    check("t5_nt_no_err", 32'(early), 32'h0);
    s_if.ack   = 1'b1;
    s_if.dat_r = 32'hCAFE_F00D;
    #1;
    check("t5_nt_ack", 32'(m0n_if.ack), 32'h1);
    check("t5_nt_dat", m0n_if.dat_r, 32'hCAFE_F00D);
    check("t5_nt_err", 32'(m0n_if.err), 32'h0);
    tick();
    idle_all();
    tick();

    // ---------------- reset while m1 owns with stb pending
    set_m1(1'b1, 1'b1, 1'b1, 32'h3000_0010, 32'h5555_AAAA);
    tick();
    check("t6_own1", 32'(grant), 32'h2);
    check("t6_wbs_cyc_on", 32'(s_if.cyc), 32'h1);
    rst = 1'b1;
    tick();
    check("t6_grant", 32'(grant), 32'h0);
    check("t6_wbs_cyc", 32'(s_if.cyc), 32'h0);
    check("t6_wbs_stb", 32'(s_if.stb), 32'h0);
    check("t6_wbs_we", 32'(s_if.we), 32'h0);
    check("t6_wbs_adr", s_if.adr, 32'h0);
    check("t6_wbs_dat", s_if.dat_w, 32'h0);
    check("t6_m1_ack", 32'(m1_if.ack), 32'h0);
    check("t6_m1_err", 32'(m1_if.err), 32'h0);
    check("t6_timeout", 32'(timeout), 32'h0);
    rst = 1'b0;
    set_m0(1'b1, 1'b1, 1'b0, 32'h3000_0000, 32'h0);
    tick();
    check("t6_first_tie_m0", 32'(grant), 32'h1);
    idle_all();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
